// File: rtl/bp_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bp_update_ctrl
// Purpose  : gshare/bimodal branch-predictor update controller with in-flight FIFO
//            (gshare history enabled by defining BP_GHR_EN)
// Revision : 1.0
// ============================================================================
module bp_update_ctrl #(
    parameter int INDEX_WIDTH = 12,
    parameter int DEPTH       = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   pred_valid_i,
    input  logic [31:0]            pred_pc_i,
    input  logic                   pred_taken_i,
    output logic                   pred_ready_o,
    output logic [INDEX_WIDTH-1:0] rd_index_o,
    input  logic                   res_valid_i,
    input  logic                   res_taken_i,
    output logic                   update_en_o,
    output logic [INDEX_WIDTH-1:0] update_index_o,
    output logic                   br_taken_o,
    output logic                   mispredict_o,
    output logic                   empty_o,
    output logic                   full_o
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [c_CNT_W-1:0]     count_q, count_d;
    logic [c_PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [INDEX_WIDTH-1:0] idx_mem_q [DEPTH];
    logic [DEPTH-1:0]       pred_mem_q;

    logic                   upd_en_q;
    logic [INDEX_WIDTH-1:0] upd_idx_q;
    logic                   br_taken_q;
    logic                   mispred_q;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_mis;
    logic [INDEX_WIDTH-1:0] w_pc_idx;
    logic                   w_unused_pc;

    assign w_pc_idx    = pred_pc_i[INDEX_WIDTH+1:2];
    assign w_unused_pc = ^{pred_pc_i[31:INDEX_WIDTH+2], pred_pc_i[1:0]};

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == c_CNT_W'(DEPTH));

    assign w_pop = res_valid_i && !empty_o;
    assign w_mis = w_pop && (res_taken_i != pred_mem_q[rd_ptr_q]);

    // A correct pop frees a slot this cycle, so a full FIFO may still accept a push.
    assign pred_ready_o = (!full_o || w_pop) && !w_mis;
    assign w_push       = pred_valid_i && pred_ready_o;

`ifdef BP_GHR_EN
    logic [INDEX_WIDTH-1:0] spec_ghr_q, spec_ghr_d;
    logic [INDEX_WIDTH-1:0] arch_ghr_q, arch_ghr_d;

    assign rd_index_o = w_pc_idx ^ spec_ghr_q;

    always_comb begin
        arch_ghr_d = arch_ghr_q;
        spec_ghr_d = spec_ghr_q;
        if (w_pop) begin
            arch_ghr_d = {arch_ghr_q[INDEX_WIDTH-2:0], res_taken_i};
        end
        if (w_mis) begin
            spec_ghr_d = arch_ghr_d;
        end else if (w_push) begin
            spec_ghr_d = {spec_ghr_q[INDEX_WIDTH-2:0], pred_taken_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            spec_ghr_q <= '0;
            arch_ghr_q <= '0;
        end else begin
            spec_ghr_q <= spec_ghr_d;
            arch_ghr_q <= arch_ghr_d;
        end
    end
`else
    assign rd_index_o = w_pc_idx;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_mis) begin
            // Flush: any push this cycle was already blocked via pred_ready_o.
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
            end
            count_d = count_q + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            upd_en_q   <= 1'b0;
            upd_idx_q  <= '0;
            br_taken_q <= 1'b0;
            mispred_q  <= 1'b0;
        end else begin
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            upd_en_q  <= w_pop;
            mispred_q <= w_mis;
            if (w_pop) begin
                upd_idx_q  <= idx_mem_q[rd_ptr_q];
                br_taken_q <= res_taken_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            idx_mem_q[wr_ptr_q]  <= rd_index_o;
            pred_mem_q[wr_ptr_q] <= pred_taken_i;
        end
    end

    assign update_en_o    = upd_en_q;
    assign update_index_o = upd_idx_q;
    assign br_taken_o     = br_taken_q;
    assign mispredict_o   = mispred_q;

endmodule
`default_nettype wire

// File: tb/tb_bp_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_update_ctrl
// Purpose  : scoreboard bench for bp_update_ctrl against a queue-based model
// Revision : 1.0
// ============================================================================
module tb_bp_update_ctrl;

    localparam int IW    = 12;
    localparam int DEPTH = 4;
`ifdef BP_GHR_EN
    localparam bit GHR_EN = 1'b1;
`else
    localparam bit GHR_EN = 1'b0;
`endif

    logic          clk_i;
    logic          rst_i;
    logic          pred_valid_i;
    logic [31:0]   pred_pc_i;
    logic          pred_taken_i;
    logic          pred_ready_o;
    logic [IW-1:0] rd_index_o;
    logic          res_valid_i;
    logic          res_taken_i;
    logic          update_en_o;
    logic [IW-1:0] update_index_o;
    logic          br_taken_o;
    logic          mispredict_o;
    logic          empty_o;
    logic          full_o;

    bp_update_ctrl #(.INDEX_WIDTH(IW), .DEPTH(DEPTH)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .pred_valid_i   (pred_valid_i),
        .pred_pc_i      (pred_pc_i),
        .pred_taken_i   (pred_taken_i),
        .pred_ready_o   (pred_ready_o),
        .rd_index_o     (rd_index_o),
        .res_valid_i    (res_valid_i),
        .res_taken_i    (res_taken_i),
        .update_en_o    (update_en_o),
        .update_index_o (update_index_o),
        .br_taken_o     (br_taken_o),
        .mispredict_o   (mispredict_o),
        .empty_o        (empty_o),
        .full_o         (full_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [IW-1:0] idx;
        logic          pred;
    } ent_t;

    typedef struct {
        logic [IW-1:0] idx;
        logic          taken;
        logic          mis;
    } upd_t;

    ent_t          mq[$];
    upd_t          sb[$];
    logic [IW-1:0] m_spec;
    logic [IW-1:0] m_arch;
    logic [IW-1:0] last_rd_index;
    int            n_checks;
    int            n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: evaluated just before the rising edge that commits it.
    task automatic model_step();
        logic [IW-1:0] e_idx;
        logic          pop, mis, rdy;
        upd_t          u;
        ent_t          e;
        e_idx = pred_pc_i[IW+1:2] ^ (GHR_EN ? m_spec : '0);
        pop   = res_valid_i && (mq.size() > 0);
        mis   = pop && (res_taken_i != mq[0].pred);
        rdy   = !mis && ((mq.size() < DEPTH) || pop);
        last_rd_index = rd_index_o;
        chk("rd_index", 32'(rd_index_o), 32'(e_idx));
        chk("pred_ready", 32'(pred_ready_o), 32'(rdy));
        chk("full", 32'(full_o), 32'(mq.size() == DEPTH));
        chk("empty", 32'(empty_o), 32'(mq.size() == 0));
        if (pop) begin
            u.idx   = mq[0].idx;
            u.taken = res_taken_i;
            u.mis   = mis;
            sb.push_back(u);
            void'(mq.pop_front());
            m_arch = {m_arch[IW-2:0], res_taken_i};
        end
        if (mis) begin
            mq.delete();
            m_spec = m_arch;
        end else if (pred_valid_i && rdy) begin
            e.idx  = e_idx;
            e.pred = pred_taken_i;
            mq.push_back(e);
            m_spec = {m_spec[IW-2:0], pred_taken_i};
        end
    endtask

    task automatic cycle(input logic pv, input logic [31:0] pc, input logic pt,
                         input logic rv, input logic rt);
        @(negedge clk_i);
        pred_valid_i = pv;
        pred_pc_i    = pc;
        pred_taken_i = pt;
        res_valid_i  = rv;
        res_taken_i  = rt;
        #1;
        model_step();
    endtask

    task automatic check_reset();
        chk("rst_update_en", 32'(update_en_o), 32'd0);
        chk("rst_update_index", 32'(update_index_o), 32'd0);
        chk("rst_br_taken", 32'(br_taken_o), 32'd0);
        chk("rst_mispredict", 32'(mispredict_o), 32'd0);
        chk("rst_empty", 32'(empty_o), 32'd1);
        chk("rst_full", 32'(full_o), 32'd0);
        chk("rst_ready", 32'(pred_ready_o), 32'd1);
        chk("rst_rd_index", 32'(rd_index_o), 32'd0);
    endtask

    // Asserts reset immediately (asynchronous) and checks outputs before any edge.
    task automatic reset_now();
        rst_i        = 1'b0;
        pred_valid_i = 1'b0;
        pred_pc_i    = '0;
        pred_taken_i = 1'b0;
        res_valid_i  = 1'b0;
        res_taken_i  = 1'b0;
        mq.delete();
        sb.delete();
        m_spec = '0;
        m_arch = '0;
        #1;
        check_reset();
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        reset_now();
        @(posedge clk_i);
        #1;
        check_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    // Monitor: every update pulse is matched against the oldest expected update.
    initial begin
        upd_t u;
        forever begin
            @(posedge clk_i);
            #1;
            if (update_en_o) begin
                if (sb.size() == 0) begin
                    chk("spurious_update", 32'(update_en_o), 32'd0);
                end else begin
                    u = sb.pop_front();
                    chk("update_index", 32'(update_index_o), 32'(u.idx));
                    chk("br_taken", 32'(br_taken_o), 32'(u.taken));
                    chk("mispredict", 32'(mispredict_o), 32'(u.mis));
                end
            end else begin
                chk("mispredict_idle", 32'(mispredict_o), 32'd0);
            end
        end
    end

    initial begin
        logic rt;
        n_checks = 0;
        n_fail   = 0;
        reset_now();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;

        // Single push, mispredicted resolve.
        cycle(1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("mispredict_flush_empty", 32'(empty_o), 32'd1);

        // History build-up, fill, blocked 5th push, in-order drain.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h40, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
        chk("gshare_idx", 32'(last_rd_index), GHR_EN ? 32'h017 : 32'h010);
        cycle(1'b1, 32'h80, 1'b1, 1'b0, 1'b0);
        chk("full_blocks_push", 32'(pred_ready_o), 32'd0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1, mq[0].pred);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("drained_empty", 32'(empty_o), 32'd1);

        // Full FIFO accepts a push alongside a correct pop.
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h100 + 32'(i * 4), i[0], 1'b0, 1'b0);
        cycle(1'b1, 32'h200, 1'b1, 1'b1, mq[0].pred);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Mispredict with simultaneous push: push dropped, spec history restored.
        do_reset();
        cycle(1'b1, 32'h300, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'h304, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h308, 1'b1, 1'b1, ~mq[0].pred);
        cycle(1'b1, 32'h30c, 1'b0, 1'b0, 1'b0);

        // Resolve while empty is ignored.
        do_reset();
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 32'h44, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic, predictions mostly correct so the FIFO fills.
        for (int i = 0; i < 1500; i++) begin
            if (mq.size() > 0 && ($urandom % 6) != 0) rt = mq[0].pred;
            else rt = 1'($urandom);
            cycle(($urandom % 4) != 0, $urandom, 1'($urandom), ($urandom % 5) < 2, rt);
        end
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset while an update pulse is being presented.
        do_reset();
        cycle(1'b1, 32'h500, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'h504, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        @(negedge clk_i);
        reset_now();
        @(posedge clk_i);
        #1;
        check_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bp_update_ctrl.md
BP_UPDATE_CTRL -- requirements
Module: bp_update_ctrl

Interface
REQ-001 The block SHALL have parameter INDEX_WIDTH, default 12, giving the PHT index width and the GHR width.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the in-flight branch FIFO entries (power of 2, at least 2).
REQ-003 clk_i  in  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst_i  in  1  reset, asynchronous and active-low.
REQ-005 pred_valid_i  in  1  fetch presents a predicted branch this cycle.
REQ-006 pred_pc_i  in  32  PC of that branch.
REQ-007 pred_taken_i  in  1  prediction bit read back from the PHT at rd_index_o.
REQ-008 pred_ready_o  out  1  FIFO can accept a push (not full and no flush this cycle).
REQ-009 rd_index_o  out  INDEX_WIDTH  PHT read index, combinational.
REQ-010 res_valid_i  in  1  execute resolves the oldest in-flight branch (in program order).
REQ-011 res_taken_i  in  1  actual branch outcome.
REQ-012 update_en_o, update_index_o[INDEX_WIDTH-1:0], br_taken_o  out  PHT update port, registered.
REQ-013 mispredict_o  out  1  registered, one-cycle pulse on a resolved misprediction.
REQ-014 empty_o, full_o  out  1  FIFO status.

Function
REQ-015 The gshare index SHALL be formed as rd_index_o = pred_pc_i[INDEX_WIDTH+1:2] XOR spec_ghr.
REQ-016 A push SHALL occur when pred_valid_i and pred_ready_o are both 1, storing {rd_index_o, pred_taken_i} at the tail.
REQ-017 On a push, the next spec_ghr SHALL be {spec_ghr[INDEX_WIDTH-2:0], pred_taken_i}.
REQ-018 A pop SHALL occur when res_valid_i is 1 and the FIFO is not empty; res_valid_i while empty SHALL be ignored with no update and no state change.
REQ-019 On a pop, the next cycle SHALL present update_en_o=1, update_index_o=stored index and br_taken_o=res_taken_i (latency 1).
REQ-020 On a pop, the next arch_ghr SHALL be {arch_ghr[INDEX_WIDTH-2:0], res_taken_i}.
REQ-021 A pop SHALL be a mispredict when res_taken_i differs from the stored prediction; mispredict_o SHALL pulse 1 in the following cycle.
REQ-022 On a mispredict, the FIFO SHALL be flushed (count=0) and spec_ghr SHALL be set to the new arch_ghr value.
REQ-023 On a mispredict, pred_ready_o SHALL be combinationally 0 in that same cycle, so any simultaneous push is dropped.
REQ-024 A simultaneous push and correct-prediction pop SHALL both occur, leave the count unchanged and be allowed when full.
REQ-025 Pointers SHALL wrap modulo DEPTH; full_o SHALL equal (count==DEPTH) and empty_o SHALL equal (count==0).
REQ-026 update_en_o and mispredict_o SHALL be 0 in any cycle not following a pop.

Reset
REQ-027 While rst_i=0, the block SHALL hold count=0, both pointers=0, spec_ghr=0, arch_ghr=0, update_en_o=0, update_index_o=0, br_taken_o=0 and mispredict_o=0.
REQ-028 While rst_i=0, empty_o SHALL be 1, full_o 0 and pred_ready_o 1.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight entries and suppress any pending update pulse.

Configuration
REQ-030 Macro BP_GHR_EN defined: the block SHALL implement gshare indexing and the GHR registers as described above.
REQ-031 Macro BP_GHR_EN undefined: rd_index_o SHALL equal pred_pc_i[INDEX_WIDTH+1:2] (bimodal), with no GHR registers; FIFO, update and mispredict behaviour is unchanged.

Verification
REQ-032 Reset, then push pc=0x0000_0010 with pred_taken=0 and resolve taken -> next cycle update_en_o=1, update_index_o=0x004, br_taken_o=1, mispredict_o=1, empty_o=1.
REQ-033 (BP_GHR_EN) Push 3 taken predictions at pc=0x40 with no resolves -> 4th rd_index_o=0x010^0x007=0x017.
REQ-034 Push 4 entries -> full_o=1, pred_ready_o=0; a 5th pred_valid_i is not stored; then resolve 4 correct -> 4 update pulses in order, empty_o=1.
REQ-035 With 2 entries held, a mispredicted resolve plus a push in the same cycle -> push dropped, count=0, spec_ghr equals arch_ghr.
REQ-036 res_valid_i=1 while empty -> update_en_o stays 0 and arch_ghr is unchanged.
REQ-037 rst_i driven low between a pop and its update cycle -> update_en_o=0 and all outputs at their reset values.
